// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcode encoding and FSM state type shared by the multi-cycle ALU.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_DIVU = 4'b0100;
  localparam logic [3:0] OP_REMU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : seq_muldiv_unit
// Brief    : Iterative shift-add multiplier and restoring divider, one bit per
//            cycle. Used by multicycle_alu only when ALU_MULDIV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module seq_muldiv_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_div;
  logic             r_rem;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;

  logic [WIDTH:0]   w_rem_sh;
  logic             w_qbit;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;

  // Divide: r_a shifts the dividend out MSB-first and the quotient in LSB-first,
  // r_acc holds the partial remainder. Multiply: r_a is the shifted multiplicand.
  always_comb begin
    w_rem_sh = {r_acc, r_a[WIDTH-1]};
    w_qbit   = (w_rem_sh >= {1'b0, r_b});
    if (r_div) begin
      w_acc_nxt = w_qbit ? (w_rem_sh[WIDTH-1:0] - r_b) : w_rem_sh[WIDTH-1:0];
      w_a_nxt   = {r_a[WIDTH-2:0], w_qbit};
      w_b_nxt   = r_b;
    end else begin
      w_acc_nxt = r_acc + (r_b[0] ? r_a : '0);
      w_a_nxt   = r_a << 1;
      w_b_nxt   = r_b >> 1;
    end
  end

  // The final step's value is presented combinationally so the ALU can latch it
  // on the same edge that the counter runs out.
  assign done   = (r_cnt == CNT_W'(1));
  assign result = (r_div && !r_rem) ? w_a_nxt : w_acc_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_div <= 1'b0;
      r_rem <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (start) begin
      r_cnt <= CNT_W'(WIDTH);
      r_div <= (op != OP_MUL);
      r_rem <= (op == OP_REMU);
      r_a   <= operand1;
      r_b   <= operand2;
      r_acc <= '0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
      r_a   <= w_a_nxt;
      r_b   <= w_b_nxt;
      r_acc <= w_acc_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_alu
// Brief    : Registered ALU with valid/ready handshake on both sides. Iterative
//            MUL/DIVU/REMU are built only when ALU_MULDIV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             is_zero,
  output logic             busy
);

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_ovf;
  logic             r_zero;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_c;
  logic             w_alu_v;

  always_comb begin
    w_sum     = {1'b0, operand1} + {1'b0, operand2};
    w_sub     = {1'b0, operand1} + {1'b0, ~operand2} + {{WIDTH{1'b0}}, 1'b1};
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (op)
      OP_AND:  w_alu_res = operand1 & operand2;
      OP_OR:   w_alu_res = operand1 | operand2;
      OP_NOR:  w_alu_res = ~(operand1 | operand2);
      OP_ADD: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_res = w_sub[WIDTH-1:0];
        w_alu_c   = w_sub[WIDTH];
        w_alu_v   = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                    (w_sub[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (operand1 < operand2)};
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
      default: w_alu_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  logic             r_busy;
  logic             w_md_start;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_result;

  assign w_md_start = (r_state == ST_IDLE) && in_valid && is_muldiv(op);

  seq_muldiv_unit #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_md_start),
    .op       (op),
    .operand1 (operand1),
    .operand2 (operand2),
    .done     (w_md_done),
    .result   (w_md_result)
  );

  assign busy = r_busy;
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
  assign busy         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b1;
`ifdef ALU_MULDIV_EN
      r_busy      <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
`ifdef ALU_MULDIV_EN
            if (is_muldiv(op)) begin
              r_state <= (op == OP_MUL) ? ST_MUL : ST_DIV;
              r_busy  <= 1'b1;
            end else
`endif
            begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_alu_res;
              r_carry     <= w_alu_c;
              r_ovf       <= w_alu_v;
              r_zero      <= (w_alu_res == '0);
            end
          end
        end
`ifdef ALU_MULDIV_EN
        ST_MUL, ST_DIV: begin
          if (w_md_done) begin
            r_state     <= ST_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_result    <= w_md_result;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= (w_md_result == '0);
          end
        end
`endif
        ST_DONE: begin
          // Re-arm only after the consumer has taken the result; a request
          // presented in this cycle waits for the following IDLE cycle.
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carry_out = r_carry;
  assign overflow  = r_ovf;
  assign is_zero   = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_alu
// Brief    : Self-checking bench for multicycle_alu; expectations follow
//            ALU_MULDIV_EN so either build can be exercised.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_alu;
  import alu_pkg::*;

  localparam int WIDTH = 32;
`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  localparam int MD_LAT = MD ? WIDTH + 1 : 1;

  typedef struct {
    int               tag;
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
    logic             z;
  } exp_t;

  typedef struct {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    exp_t             e;
    int               lat;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             is_zero;
  logic             busy;

  always #5 clk = ~clk;

  multicycle_alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand1  (operand1),
    .operand2  (operand2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .is_zero   (is_zero),
    .busy      (busy)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sbq[$];
  exp_t cur_exp;
  vec_t vecs[$];
  logic hold_bad;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, expv);
  endtask

  function automatic exp_t mk(input int tag, input logic [WIDTH-1:0] res,
                              input logic c, input logic v);
    exp_t e;
    e.tag = tag; e.res = res; e.c = c; e.v = v; e.z = (res == '0);
    return e;
  endfunction

  task automatic add_vec(input logic [3:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] res, input logic c, input logic v, input int lat);
    vec_t t;
    t.op = o; t.a = a; t.b = b; t.lat = lat;
    t.e = mk(vecs.size(), res, c, v);
    vecs.push_back(t);
  endtask

  // Scoreboard: expectation enters on acceptance, leaves on output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sbq.delete();
    end else begin
      if (in_valid && in_ready) sbq.push_back(cur_exp);
      if (out_valid && out_ready) begin
        chk("sb_has_entry", WIDTH'(sbq.size() != 0), WIDTH'(1));
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk($sformatf("t%0d_result", e.tag), result, e.res);
          chk($sformatf("t%0d_carry", e.tag), WIDTH'(carry_out), WIDTH'(e.c));
          chk($sformatf("t%0d_overflow", e.tag), WIDTH'(overflow), WIDTH'(e.v));
          chk($sformatf("t%0d_is_zero", e.tag), WIDTH'(is_zero), WIDTH'(e.z));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input vec_t v);
    int   lat;
    int   busy_cnt;
    logic rdy_bad;
    chk($sformatf("t%0d_ready_before", v.e.tag), WIDTH'(in_ready), WIDTH'(1));
    op = v.op; operand1 = v.a; operand2 = v.b; cur_exp = v.e; in_valid = 1'b1;
    step();
    // Scramble the inputs: captured operands must not be disturbed.
    in_valid = 1'b0; op = 4'($urandom); operand1 = $urandom; operand2 = $urandom;
    lat = 1; busy_cnt = 0; rdy_bad = 1'b0;
    while (!out_valid && lat < 200) begin
      if (busy) busy_cnt++;
      if (in_ready) rdy_bad = 1'b1;
      step();
      lat++;
    end
    chk($sformatf("t%0d_latency", v.e.tag), lat, v.lat);
    chk($sformatf("t%0d_busy_cycles", v.e.tag), busy_cnt, v.lat - 1);
    chk($sformatf("t%0d_ready_low", v.e.tag), WIDTH'(rdy_bad | in_ready), WIDTH'(0));
    step();
    chk($sformatf("t%0d_ready_after", v.e.tag), WIDTH'(in_ready), WIDTH'(1));
    chk($sformatf("t%0d_valid_after", v.e.tag), WIDTH'(out_valid), WIDTH'(0));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; operand1 = '0; operand2 = '0;
    cur_exp = mk(-1, '0, 1'b0, 1'b0);
    hold_bad = 1'b0;

    add_vec(OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1);
    add_vec(OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1);
    add_vec(OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1);
    add_vec(OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1);
    add_vec(OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1);
    add_vec(OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1);
    add_vec(OP_SUB,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0, 1);
    add_vec(OP_SUB,  32'h00000001, 32'hFFFFFFFF, 32'h00000002, 1'b0, 1'b0, 1);
    add_vec(OP_SLT,  32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1);
    add_vec(OP_SLTU, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 1'b0, 1'b0, 1);
    add_vec(OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1);
    add_vec(OP_OR,   32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 1);
    add_vec(OP_NOR,  32'hF0F0F0F0, 32'h0F0F0F00, 32'h0000000F, 1'b0, 1'b0, 1);
    add_vec(OP_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1);
    add_vec(4'b1111, 32'h0000FFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1);
    add_vec(4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1);
    add_vec(OP_MUL,  32'h00012345, 32'h00000100, MD ? 32'h01234500 : 32'h0, 1'b0, 1'b0, MD_LAT);
    add_vec(OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, MD ? 32'h00000001 : 32'h0, 1'b0, 1'b0, MD_LAT);
    add_vec(OP_DIVU, 32'd100,      32'd7,        MD ? 32'd14 : 32'h0,       1'b0, 1'b0, MD_LAT);
    add_vec(OP_REMU, 32'd100,      32'd7,        MD ? 32'd2 : 32'h0,        1'b0, 1'b0, MD_LAT);
    add_vec(OP_DIVU, 32'd5,        32'd0,        MD ? 32'hFFFFFFFF : 32'h0, 1'b0, 1'b0, MD_LAT);
    add_vec(OP_REMU, 32'd5,        32'd0,        MD ? 32'd5 : 32'h0,        1'b0, 1'b0, MD_LAT);
    add_vec(OP_DIVU, 32'hFFFFFFFF, 32'h10,       MD ? 32'h0FFFFFFF : 32'h0, 1'b0, 1'b0, MD_LAT);
    add_vec(OP_REMU, 32'hFFFFFFFF, 32'h10,       MD ? 32'h0000000F : 32'h0, 1'b0, 1'b0, MD_LAT);
    add_vec(OP_DIVU, 32'd7,        32'd100,      32'h0,                     1'b0, 1'b0, MD_LAT);

    repeat (3) step();
    chk("rst_result", result, '0);
    chk("rst_carry", WIDTH'(carry_out), WIDTH'(0));
    chk("rst_overflow", WIDTH'(overflow), WIDTH'(0));
    chk("rst_is_zero", WIDTH'(is_zero), WIDTH'(1));
    chk("rst_out_valid", WIDTH'(out_valid), WIDTH'(0));
    chk("rst_in_ready", WIDTH'(in_ready), WIDTH'(1));
    chk("rst_busy", WIDTH'(busy), WIDTH'(0));
    rst_n = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) issue(vecs[i]);

    // Backpressure: result held for 10 cycles while a new request is ignored.
    out_ready = 1'b0;
    op = OP_AND; operand1 = 32'hF0F0F0F0; operand2 = 32'hFF00FF00;
    cur_exp = mk(100, 32'hF000F000, 1'b0, 1'b0); in_valid = 1'b1;
    step();
    op = OP_NOR; operand1 = '0; operand2 = '0; cur_exp = mk(101, 32'hFFFFFFFF, 1'b0, 1'b0);
    hold_bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!out_valid || result !== 32'hF000F000 || in_ready) hold_bad = 1'b1;
      step();
    end
    chk("bp_hold_stable", WIDTH'(hold_bad), WIDTH'(0));
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("bp_release_ready", WIDTH'(in_ready), WIDTH'(1));
    chk("bp_release_valid", WIDTH'(out_valid), WIDTH'(0));

    // Request presented during the DONE/out_ready cycle waits one IDLE cycle.
    op = OP_ADD; operand1 = 32'd1; operand2 = 32'd1;
    cur_exp = mk(102, 32'd2, 1'b0, 1'b0); in_valid = 1'b1;
    step();
    chk("dc_first_valid", WIDTH'(out_valid), WIDTH'(1));
    op = OP_OR; operand1 = 32'h10; operand2 = 32'h01; cur_exp = mk(103, 32'h11, 1'b0, 1'b0);
    step();
    chk("dc_wait_ready", WIDTH'(in_ready), WIDTH'(1));
    chk("dc_wait_valid", WIDTH'(out_valid), WIDTH'(0));
    step();
    in_valid = 1'b0;
    chk("dc_taken_valid", WIDTH'(out_valid), WIDTH'(1));
    chk("dc_taken_result", result, 32'h11);
    step();

    // Reset 10 cycles after a MUL is accepted.
    op = OP_MUL; operand1 = 32'h00012345; operand2 = 32'h00000100;
    cur_exp = mk(104, MD ? 32'h01234500 : 32'h0, 1'b0, 1'b0); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    chk("rm_busy_mid", WIDTH'(busy), WIDTH'(MD));
    rst_n = 1'b0;
    step();
    chk("rm_result", result, '0);
    chk("rm_is_zero", WIDTH'(is_zero), WIDTH'(1));
    chk("rm_out_valid", WIDTH'(out_valid), WIDTH'(0));
    chk("rm_in_ready", WIDTH'(in_ready), WIDTH'(1));
    chk("rm_busy", WIDTH'(busy), WIDTH'(0));
    rst_n = 1'b1;
    begin
      vec_t t;
      t.op = OP_ADD; t.a = 32'd2; t.b = 32'd3; t.lat = 1;
      t.e = mk(105, 32'd5, 1'b0, 1'b0);
      issue(t);
    end

    repeat (2) step();
    chk("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
